// File: rtl/sample_flow_rx.sv
// Purpose:      receive bytes from a remote strobe-based sample-flow transmitter into a small FIFO.
// Latency:      with SYNC_STAGES=2, a byte is at the FIFO head after the 3rd clk edge that samples rx_stb high.
// Backpressure: valid/ready output; when full, new bytes are dropped (sticky overflow) unless a pop happens in the same cycle.
//
// Ports:
//   clk, reset          single clock; asynchronous active-high reset
//   rx_data/rx_stb/rx_par  remote byte, strobe (rising edge = new byte), even-parity bit
//   out_data/out_valid/out_ready  FIFO head, valid/ready handshake
//   seg                 hex seven-segment image of the last accepted byte's low nibble (seg[0]=a .. seg[6]=g)
//   level               FIFO occupancy, 0..DEPTH
//   overflow            sticky: a byte was dropped because the FIFO was full
//   parity_err          sticky: a byte was dropped on parity mismatch
//
// Build option: define SAMPLE_FLOW_RX_PARITY_EN to check even parity on rx_par; otherwise
// rx_par is ignored and parity_err is tied low.
// DEPTH must be a power of two in 2..16; SYNC_STAGES must be at least 2.
module sample_flow_rx #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_stb,
  input  logic                     rx_par,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [6:0]               seg,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     parity_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Input synchronizers. Data, parity and strobe move in lockstep so the byte
  // seen at the capture point is the one the strobe edge announced.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0]      stb_sync;
  logic [SYNC_STAGES-1:0][7:0] data_sync;
  logic                        stb_hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stb_sync  <= '0;
      data_sync <= '0;
      stb_hist  <= 1'b0;
    end else begin
      stb_sync  <= {stb_sync[SYNC_STAGES-2:0], rx_stb};
      data_sync <= {data_sync[SYNC_STAGES-2:0], rx_data};
      stb_hist  <= stb_sync[SYNC_STAGES-1];
    end
  end

  logic [7:0] byte_s;
  logic       capture;
  logic       par_bad;

  assign byte_s  = data_sync[SYNC_STAGES-1];
  // Only a synchronized 0->1 transition captures; a held strobe captures once.
  // The history flop resets to 0, so a strobe held across reset release is a new edge.
  assign capture = stb_sync[SYNC_STAGES-1] & ~stb_hist;

`ifdef SAMPLE_FLOW_RX_PARITY_EN
  logic [SYNC_STAGES-1:0] par_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_sync <= '0;
    end else begin
      par_sync <= {par_sync[SYNC_STAGES-2:0], rx_par};
    end
  end

  // Even parity: the 9-bit XOR over {par, data} must be zero.
  assign par_bad = ^{par_sync[SYNC_STAGES-1], byte_s};

  // Parity drop wins over a full FIFO, so only parity_err records it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (capture && par_bad) begin
      parity_err <= 1'b1;
    end
  end
`else
  logic unused_rx_par;

  assign unused_rx_par = rx_par;
  assign par_bad       = 1'b0;
  assign parity_err    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FIFO. Storage is reset so out_data reads 0 immediately under reset.
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0][7:0] mem;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop_full;

  assign full      = (count == FULL_LVL);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push      = capture & ~par_bad & (~full | pop);
  assign drop_full = capture & ~par_bad & full & ~pop;

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign level     = count;

  // Hex digit to segments, bit 0 = a ... bit 6 = g, active-high.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    hex7 = 7'b0000000;
    case (n)
      4'h0: hex7 = 7'b0111111;
      4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;
      4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;
      4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;
      4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b1011000;  // lowercase c
      4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;
      4'hF: hex7 = 7'b1110001;
      default: hex7 = 7'b0000000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seg      <= 7'b0000000;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= byte_s;
        wr_ptr      <= wr_ptr + 1'b1;  // wraps modulo DEPTH (power of two)
        seg         <= hex7(byte_s[3:0]);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (drop_full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_flow_rx.sv
// Directed bench for sample_flow_rx with DEPTH=4, SYNC_STAGES=2.
// Table-driven byte transfers plus hand-written latency, backpressure and reset sequences.
module tb_sample_flow_rx;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_stb;
  logic       rx_par;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] seg;
  logic [2:0] level;
  logic       overflow;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  sample_flow_rx #(.DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_stb     (rx_stb),
    .rx_par     (rx_par),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .seg        (seg),
    .level      (level),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] head;
    logic [2:0] lvl;
    logic [6:0] seg;
    logic       ovf;
  } vec_t;

  vec_t rt_tab[11];
  vec_t fill_tab[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with the byte written and the strobe idle.
  task automatic send_byte(input logic [7:0] d, input logic p);
    rx_data = d;
    rx_par  = p;
    rx_stb  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx_stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_level"}, 32'(level), 32'd0);
    check({name, "_valid"}, 32'(out_valid), 32'd0);
    check({name, "_data"}, 32'(out_data), 32'd0);
    check({name, "_seg"}, 32'(seg), 32'd0);
    check({name, "_ovf"}, 32'(overflow), 32'd0);
    check({name, "_perr"}, 32'(parity_err), 32'd0);
  endtask

  initial begin
    // Single-byte round trips covering the segment decoder.
    rt_tab[0]  = '{8'h30, 8'h30, 3'd1, 7'b0111111, 1'b0};
    rt_tab[1]  = '{8'h3C, 8'h3C, 3'd1, 7'b1011000, 1'b0};
    rt_tab[2]  = '{8'h5A, 8'h5A, 3'd1, 7'b1110111, 1'b0};
    rt_tab[3]  = '{8'hEF, 8'hEF, 3'd1, 7'b1110001, 1'b0};
    rt_tab[4]  = '{8'h98, 8'h98, 3'd1, 7'b1111111, 1'b0};
    rt_tab[5]  = '{8'h0B, 8'h0B, 3'd1, 7'b1111100, 1'b0};
    rt_tab[6]  = '{8'h1D, 8'h1D, 3'd1, 7'b1011110, 1'b0};
    rt_tab[7]  = '{8'h2E, 8'h2E, 3'd1, 7'b1111001, 1'b0};
    rt_tab[8]  = '{8'h47, 8'h47, 3'd1, 7'b0000111, 1'b0};
    rt_tab[9]  = '{8'h66, 8'h66, 3'd1, 7'b1111101, 1'b0};
    rt_tab[10] = '{8'h79, 8'h79, 3'd1, 7'b1101111, 1'b0};
    // Fill with out_ready low; the fifth byte overflows and is dropped.
    fill_tab[0] = '{8'h01, 8'h01, 3'd1, 7'b0000110, 1'b0};
    fill_tab[1] = '{8'h02, 8'h01, 3'd2, 7'b1011011, 1'b0};
    fill_tab[2] = '{8'h03, 8'h01, 3'd3, 7'b1001111, 1'b0};
    fill_tab[3] = '{8'h04, 8'h01, 3'd4, 7'b1100110, 1'b0};
    fill_tab[4] = '{8'h05, 8'h01, 3'd4, 7'b1100110, 1'b1};

    // Reset state, checked before any clock edge.
    reset     = 1'b1;
    rx_data   = 8'hA5;
    rx_stb    = 1'b0;
    rx_par    = 1'b0;
    out_ready = 1'b0;
    #2;
    check_reset_outputs("reset_init");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // First-byte latency: valid rises after the 3rd edge sampling rx_stb high.
    rx_data = 8'h3C;
    rx_stb  = 1'b1;
    @(posedge clk);
    #1 check("lat_e1_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 check("lat_e2_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_e3_valid", 32'(out_valid), 32'd1);
    check("lat_e3_data", 32'(out_data), 32'h3C);
    check("lat_e3_seg", 32'(seg), 32'b1011000);
    check("lat_e3_level", 32'(level), 32'd1);
    rx_stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pop_check("lat_pop", 8'h3C);
    check("lat_pop_level", 32'(level), 32'd0);

    // Strobe held high for 10 cycles captures exactly once.
    rx_data = 8'h5A;
    rx_stb  = 1'b1;
    repeat (10) @(posedge clk);
    #1 rx_stb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("hold_level", 32'(level), 32'd1);
    pop_check("hold_pop", 8'h5A);
    check("hold_empty", 32'(level), 32'd0);

    for (int i = 0; i < 11; i++) begin
      send_byte(rt_tab[i].data, 1'b0);
      check($sformatf("rt%0d_level", i), 32'(level), 32'(rt_tab[i].lvl));
      check($sformatf("rt%0d_seg", i), 32'(seg), 32'(rt_tab[i].seg));
      check($sformatf("rt%0d_ovf", i), 32'(overflow), 32'(rt_tab[i].ovf));
      pop_check($sformatf("rt%0d_pop", i), rt_tab[i].head);
    end

    for (int i = 0; i < 5; i++) begin
      send_byte(fill_tab[i].data, 1'b0);
      check($sformatf("fill%0d_head", i), 32'(out_data), 32'(fill_tab[i].head));
      check($sformatf("fill%0d_level", i), 32'(level), 32'(fill_tab[i].lvl));
      check($sformatf("fill%0d_seg", i), 32'(seg), 32'(fill_tab[i].seg));
      check($sformatf("fill%0d_ovf", i), 32'(overflow), 32'(fill_tab[i].ovf));
    end
    for (int i = 0; i < 4; i++) begin
      pop_check($sformatf("drain%0d", i), 8'(i + 1));
    end
    check("drain_level", 32'(level), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);

    // Full FIFO, capture coincides with a pop: both complete, no overflow.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(8'h11 + i), 1'b0);
    end
    check("fp_full_level", 32'(level), 32'd4);
    rx_data = 8'h15;
    rx_stb  = 1'b1;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rx_stb    = 1'b0;
    check("fp_level", 32'(level), 32'd4);
    check("fp_ovf", 32'(overflow), 32'd0);
    check("fp_head", 32'(out_data), 32'h12);
    check("fp_seg", 32'(seg), 32'b1101101);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      pop_check($sformatf("fp_drain%0d", i), 8'(8'h12 + i));
    end
    check("fp_drain_level", 32'(level), 32'd0);

    // Reset pulsed mid-stream with a strobe in flight: outputs clear with no clock edge.
    do_reset();
    send_byte(8'h21, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h23, 1'b0);
    check("mid_level3", 32'(level), 32'd3);
    rx_data = 8'h24;
    rx_stb  = 1'b1;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_reset_outputs("mid_async");
    rx_stb = 1'b0;
    reset  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_discard_level", 32'(level), 32'd0);
    send_byte(8'h26, 1'b0);
    check("mid_next_level", 32'(level), 32'd1);
    check("mid_next_head", 32'(out_data), 32'h26);

    // Strobe held high across reset release is captured as a new edge.
    rx_data = 8'h3A;
    rx_stb  = 1'b1;
    reset   = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk);
    #1 check("relhold_e1_level", 32'(level), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("relhold_level", 32'(level), 32'd1);
    check("relhold_head", 32'(out_data), 32'h3A);
    rx_stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    do_reset();
`ifdef SAMPLE_FLOW_RX_PARITY_EN
    send_byte(8'h07, 1'b0);
    check("par_bad_level", 32'(level), 32'd0);
    check("par_bad_perr", 32'(parity_err), 32'd1);
    check("par_bad_seg", 32'(seg), 32'd0);
    send_byte(8'h07, 1'b1);
    check("par_ok_level", 32'(level), 32'd1);
    check("par_ok_head", 32'(out_data), 32'h07);
    check("par_ok_seg", 32'(seg), 32'b0000111);
    check("par_ok_perr", 32'(parity_err), 32'd1);
`else
    send_byte(8'h07, 1'b0);
    check("nopar_level", 32'(level), 32'd1);
    check("nopar_head", 32'(out_data), 32'h07);
    check("nopar_perr", 32'(parity_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
